// File: rtl/dl_pkg.sv
// Shared types and constants for the download sequencer: FSM states,
// ioctl index targets and mod_sel variant encodings.
package dl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    typedef enum logic [1:0] {
        MOD_BAGMAN = 2'd0,
        MOD_SBAG   = 2'd1,
        MOD_PICK   = 2'd2,
        MOD_SQUA   = 2'd3
    } mod_t;

    // Unknown variant bytes fall back to the base game.
    function automatic logic [1:0] mod_map(input logic [7:0] b);
        return (b > 8'd3) ? 2'(MOD_BAGMAN) : b[1:0];
    endfunction

endpackage

// File: rtl/dl_sequencer_if.sv
// ioctl download bus from the host side plus the ROM write port toward the core.
interface dl_sequencer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        dn_wr;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        input  dn_wr, dn_addr, dn_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        output dn_wr, dn_addr, dn_data
    );
endinterface

// File: rtl/dl_sequencer.sv
// Download sequencer: forwards ROM bytes to the core, validates the load size,
// holds the core in reset until a good image is in place, and latches mod/DIP bytes.
module dl_sequencer
    import dl_pkg::*;
#(
    parameter logic [16:0] ROM_BYTES   = 17'h0C000,
    parameter int          HOLD_CYCLES = 256,
    parameter logic [7:0]  DIP_DEFAULT = 8'h00
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    dl_sequencer_if.slave  io,
    input  logic           ext_reset,
    output logic           core_reset,
    output logic [1:0]     mod_sel,
    output logic [7:0]     dipsw,
    output logic           rom_ok
);

    localparam int              TW        = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0]   HOLD_LOAD = TW'(HOLD_CYCLES);
    localparam logic [17:0]     ROM_CNT   = {1'b0, ROM_BYTES};

    state_t        state;
    logic          dl_q;
    logic [17:0]   cnt;
    logic          ovf;
    logic [TW-1:0] timer;
    logic [7:0]    shadow;

    logic          dl_rise, dl_fall, wr_ok, rom_wr, rom_hit, mod_hit, dip_hit;
    logic [17:0]   cnt_nxt;
    logic          ovf_nxt;
    logic [7:0]    shadow_nxt;

    // A strobe landing on the falling-edge cycle still belongs to the download.
    always_comb begin
        dl_rise    = io.ioctl_download & ~dl_q;
        dl_fall    = ~io.ioctl_download & dl_q;
        wr_ok      = io.ioctl_wr & (io.ioctl_download | dl_fall);
        rom_wr     = wr_ok & (state == ST_LOAD) & (io.ioctl_index == IDX_ROM);
        rom_hit    = rom_wr & (io.ioctl_addr < {8'd0, ROM_BYTES});
        mod_hit    = wr_ok & (io.ioctl_index == IDX_MOD) & (io.ioctl_addr == '0);
        dip_hit    = wr_ok & (io.ioctl_index == IDX_DIP) & (io.ioctl_addr == '0);
        cnt_nxt    = (rom_hit && cnt != '1) ? cnt + 18'd1 : cnt;
        ovf_nxt    = ovf | (rom_wr & ~rom_hit);
        shadow_nxt = mod_hit ? io.ioctl_dout : shadow;
    end

    // Edge register resets high so a download still active across reset never
    // looks like a fresh edge; the host must restart the download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_WAIT;
            dl_q       <= 1'b1;
            cnt        <= '0;
            ovf        <= 1'b0;
            timer      <= '0;
            shadow     <= '0;
            core_reset <= 1'b1;
            io.dn_wr   <= 1'b0;
            io.dn_addr <= '0;
            io.dn_data <= '0;
            rom_ok     <= 1'b0;
            mod_sel    <= MOD_BAGMAN;
            dipsw      <= DIP_DEFAULT;
        end else begin
            dl_q     <= io.ioctl_download;
            io.dn_wr <= rom_hit;
            if (rom_hit) begin
                io.dn_addr <= io.ioctl_addr[16:0];
                io.dn_data <= io.ioctl_dout;
            end
            shadow <= shadow_nxt;
            if (dl_fall && io.ioctl_index == IDX_MOD) mod_sel <= mod_map(shadow_nxt);
            if (dip_hit) dipsw <= io.ioctl_dout;

            if (dl_rise && io.ioctl_index == IDX_ROM) begin
                state      <= ST_LOAD;
                cnt        <= '0;
                ovf        <= 1'b0;
                rom_ok     <= 1'b0;
                core_reset <= 1'b1;
            end else begin
                case (state)
                    ST_WAIT: core_reset <= 1'b1;
                    ST_LOAD: begin
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (dl_fall) begin
                            if (cnt_nxt == ROM_CNT && !ovf_nxt) begin
                                rom_ok <= 1'b1;
                                timer  <= HOLD_LOAD;
                                state  <= ST_HOLD;
                            end else begin
                                rom_ok <= 1'b0;
                                state  <= ST_WAIT;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (ext_reset) begin
                            timer <= HOLD_LOAD;
                        end else if (timer == '0) begin
                            state      <= ST_RUN;
                            core_reset <= 1'b0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    ST_RUN:  core_reset <= ext_reset;
                    default: state <= ST_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dl_sequencer.sv
// Directed bench for dl_sequencer: vector table inside a ROM load plus
// hand sequences for full/short/overflow loads, hold timing, mod/DIP and reset.
module tb_dl_sequencer;
    import dl_pkg::*;

    localparam logic [16:0] ROM_BYTES   = 17'h000C0;
    localparam int          N           = 192;
    localparam int          HOLD_CYCLES = 256;
    localparam logic [7:0]  DIP_DEFAULT = 8'h3C;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b1;
    logic       ext_reset = 1'b0;
    logic       core_reset, rom_ok;
    logic [1:0] mod_sel;
    logic [7:0] dipsw;

    dl_sequencer_if bus ();

    dl_sequencer #(
        .ROM_BYTES  (ROM_BYTES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .DIP_DEFAULT(DIP_DEFAULT)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .io        (bus),
        .ext_reset (ext_reset),
        .core_reset(core_reset),
        .mod_sel   (mod_sel),
        .dipsw     (dipsw),
        .rom_ok    (rom_ok)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  d;
        logic        e_wr;
        logic [16:0] e_addr;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic dl, input logic wr, input logic [7:0] idx,
                         input logic [24:0] addr, input logic [7:0] d);
        bus.ioctl_download = dl;
        bus.ioctl_wr       = wr;
        bus.ioctl_index    = idx;
        bus.ioctl_addr     = addr;
        bus.ioctl_dout     = d;
    endtask

    // Index-0 load with an idle cycle after every byte so each dn_wr pulse
    // is seen to last exactly one cycle.
    task automatic rom_load(input int nbytes, input bit ovf_byte, input bit wr_on_fall,
                            output int good, output int bad);
        bit fall_now;
        good = 0;
        bad  = 0;
        drive(1'b1, 1'b0, IDX_ROM, '0, '0);
        step();
        check("load_entry_rom_ok", 32'(rom_ok), 32'd0);
        check("load_entry_core_reset", 32'(core_reset), 32'd1);
        for (int a = 0; a < nbytes; a++) begin
            fall_now = wr_on_fall && (a == nbytes - 1);
            drive(!fall_now, 1'b1, IDX_ROM, 25'(a), 8'(a) ^ 8'h5A);
            step();
            if (bus.dn_wr === 1'b1 && bus.dn_addr === 17'(a) && bus.dn_data === (8'(a) ^ 8'h5A))
                good++;
            else
                bad++;
            if (!fall_now) begin
                drive(1'b1, 1'b0, IDX_ROM, 25'(a), 8'h00);
                step();
                if (bus.dn_wr !== 1'b0) bad++;
            end
            if (ovf_byte && a == 10) begin
                drive(1'b1, 1'b1, IDX_ROM, 25'(ROM_BYTES), 8'hEE);
                step();
                if (bus.dn_wr !== 1'b0) bad++;
                drive(1'b1, 1'b0, IDX_ROM, '0, '0);
                step();
                if (bus.dn_wr !== 1'b0) bad++;
            end
        end
        if (!wr_on_fall) begin
            drive(1'b0, 1'b0, IDX_ROM, '0, '0);
            step();
        end
        drive(1'b0, 1'b0, IDX_ROM, '0, '0);
    endtask

    // Edges counted from the download falling edge until core_reset drops.
    task automatic wait_release(input int pulse_edge, output int n);
        n = -1;
        for (int i = 1; i <= 600; i++) begin
            ext_reset = (i == pulse_edge);
            step();
            if (core_reset === 1'b0) begin
                n = i;
                break;
            end
        end
        ext_reset = 1'b0;
    endtask

    task automatic mod_dl(input logic [7:0] b0, input bit extra, input logic [1:0] prev,
                          input logic [1:0] exp, input string name);
        drive(1'b1, 1'b0, IDX_MOD, '0, '0);
        step();
        drive(1'b1, 1'b1, IDX_MOD, '0, b0);
        step();
        drive(1'b1, 1'b0, IDX_MOD, '0, '0);
        step();
        if (extra) begin
            drive(1'b1, 1'b1, IDX_MOD, 25'd1, 8'h02);
            step();
            drive(1'b1, 1'b0, IDX_MOD, '0, '0);
            step();
        end
        check({name, "_before_fall"}, 32'(mod_sel), 32'(prev));
        drive(1'b0, 1'b0, IDX_MOD, '0, '0);
        step();
        check(name, 32'(mod_sel), 32'(exp));
        drive(1'b0, 1'b0, IDX_ROM, '0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int good, bad, n, errs;
        vt[0] = '{1'b1, IDX_ROM, 25'h0000000, 8'h11, 1'b1, 17'h000, 8'h11};
        vt[1] = '{1'b0, IDX_ROM, 25'h0000000, 8'h00, 1'b0, 17'h000, 8'h11};
        vt[2] = '{1'b1, IDX_ROM, 25'h0000005, 8'h22, 1'b1, 17'h005, 8'h22};
        vt[3] = '{1'b1, IDX_ROM, 25'h00000BF, 8'h33, 1'b1, 17'h0BF, 8'h33};
        vt[4] = '{1'b1, IDX_ROM, 25'h00000C0, 8'h44, 1'b0, 17'h0BF, 8'h33};
        vt[5] = '{1'b1, IDX_ROM, 25'h1000005, 8'h55, 1'b0, 17'h0BF, 8'h33};
        vt[6] = '{1'b1, IDX_MOD, 25'h0000003, 8'h66, 1'b0, 17'h0BF, 8'h33};
        vt[7] = '{1'b1, IDX_DIP, 25'h0000001, 8'h77, 1'b0, 17'h0BF, 8'h33};
        vt[8] = '{1'b1, IDX_ROM, 25'h000007F, 8'h88, 1'b1, 17'h07F, 8'h88};

        drive(1'b0, 1'b0, IDX_ROM, '0, '0);
        #2 reset_n = 1'b0;
        #20;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("rst_dn_addr", 32'(bus.dn_addr), 32'd0);
        check("rst_dn_data", 32'(bus.dn_data), 32'd0);
        check("rst_rom_ok", 32'(rom_ok), 32'd0);
        check("rst_mod_sel", 32'(mod_sel), 32'd0);
        check("rst_dipsw", 32'(dipsw), 32'(DIP_DEFAULT));
        @(negedge clk_sys);
        reset_n = 1'b1;
        step();

        // Vector table inside one download window
        drive(1'b1, 1'b0, IDX_ROM, '0, '0);
        step();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vt[i].wr, vt[i].idx, vt[i].addr, vt[i].d);
            step();
            check($sformatf("vec%0d_dn_wr", i), 32'(bus.dn_wr), 32'(vt[i].e_wr));
            check($sformatf("vec%0d_dn_addr", i), 32'(bus.dn_addr), 32'(vt[i].e_addr));
            check($sformatf("vec%0d_dn_data", i), 32'(bus.dn_data), 32'(vt[i].e_data));
        end
        drive(1'b0, 1'b0, IDX_ROM, '0, '0);
        step();
        check("vec_ovf_rom_ok", 32'(rom_ok), 32'd0);
        check("vec_ovf_core_reset", 32'(core_reset), 32'd1);
        check("vec_dip_other_addr", 32'(dipsw), 32'(DIP_DEFAULT));
        drive(1'b0, 1'b1, IDX_ROM, '0, 8'h99);
        step();
        check("wr_no_download", 32'(bus.dn_wr), 32'd0);
        drive(1'b0, 1'b0, IDX_ROM, '0, '0);
        step();

        // Exact-size load, last byte on the falling edge, then hold timing
        rom_load(N, 1'b0, 1'b1, good, bad);
        check("full_pulses", 32'(good), 32'(N));
        check("full_bad", 32'(bad), 32'd0);
        check("full_rom_ok", 32'(rom_ok), 32'd1);
        check("full_hold_core_reset", 32'(core_reset), 32'd1);
        wait_release(0, n);
        check("hold_release_edges", 32'(n), 32'd257);

        // Mod bytes and DIP writes while running
        mod_dl(8'h03, 1'b0, 2'd0, 2'd3, "mod_03");
        mod_dl(8'h07, 1'b1, 2'd3, 2'd0, "mod_07");
        check("mod_core_reset", 32'(core_reset), 32'd0);
        drive(1'b1, 1'b0, IDX_DIP, '0, '0);
        step();
        drive(1'b1, 1'b1, IDX_DIP, 25'd0, 8'h5A);
        step();
        check("dip_load", 32'(dipsw), 32'h5A);
        drive(1'b1, 1'b1, IDX_DIP, 25'd1, 8'hFF);
        step();
        drive(1'b1, 1'b0, IDX_DIP, '0, '0);
        step();
        check("dip_addr1_ignored", 32'(dipsw), 32'h5A);
        drive(1'b0, 1'b0, IDX_ROM, '0, '0);
        step();
        check("dip_core_reset", 32'(core_reset), 32'd0);

        // ext_reset tracked in RUN
        for (int i = 0; i < 5; i++) begin
            ext_reset = (i == 0 || i == 1 || i == 3);
            step();
            check($sformatf("ext_run_%0d", i), 32'(core_reset), 32'(ext_reset));
        end
        ext_reset = 1'b0;
        step();

        // Short load from RUN: stays in WAIT
        rom_load(N - 1, 1'b0, 1'b0, good, bad);
        check("short_pulses", 32'(good), 32'(N - 1));
        check("short_rom_ok", 32'(rom_ok), 32'd0);
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (core_reset !== 1'b1) errs++;
        end
        check("short_stays_reset", 32'(errs), 32'd0);

        // Full load with one out-of-range address
        rom_load(N, 1'b1, 1'b0, good, bad);
        check("ovf_pulses", 32'(good), 32'(N));
        check("ovf_bad", 32'(bad), 32'd0);
        check("ovf_rom_ok", 32'(rom_ok), 32'd0);
        check("ovf_core_reset", 32'(core_reset), 32'd1);

        // ext_reset during HOLD restarts the timer
        rom_load(N, 1'b0, 1'b1, good, bad);
        check("hold2_rom_ok", 32'(rom_ok), 32'd1);
        wait_release(101, n);
        check("hold_ext_reload_edges", 32'(n), 32'd358);

        // Async reset in the middle of a load
        mod_dl(8'h02, 1'b0, 2'd0, 2'd2, "mod_02");
        drive(1'b1, 1'b0, IDX_ROM, '0, '0);
        step();
        for (int a = 0; a < 100; a++) begin
            drive(1'b1, 1'b1, IDX_ROM, 25'(a), 8'(a));
            step();
        end
        drive(1'b1, 1'b1, IDX_ROM, 25'd100, 8'hC4);
        #2 reset_n = 1'b0;
        #1;
        check("arst_core_reset", 32'(core_reset), 32'd1);
        check("arst_dn_wr", 32'(bus.dn_wr), 32'd0);
        check("arst_dn_addr", 32'(bus.dn_addr), 32'd0);
        check("arst_dn_data", 32'(bus.dn_data), 32'd0);
        check("arst_rom_ok", 32'(rom_ok), 32'd0);
        check("arst_mod_sel", 32'(mod_sel), 32'd0);
        check("arst_dipsw", 32'(dipsw), 32'(DIP_DEFAULT));
        @(negedge clk_sys);
        reset_n = 1'b1;
        errs = 0;
        for (int a = 101; a < 106; a++) begin
            drive(1'b1, 1'b1, IDX_ROM, 25'(a), 8'(a));
            step();
            if (bus.dn_wr !== 1'b0) errs++;
            if (core_reset !== 1'b1) errs++;
        end
        check("arst_no_dn_wr", 32'(errs), 32'd0);
        drive(1'b0, 1'b0, IDX_ROM, '0, '0);
        step();
        check("arst_end_core_reset", 32'(core_reset), 32'd1);
        check("arst_end_rom_ok", 32'(rom_ok), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
